alu: RTL and testbench

- Registered, single-cycle arithmetic/logic unit.
- Samples two unsigned WIDTH-bit operands `a` and `b` plus a 4-bit `opcode` on each rising clock edge.
- Drives a 2*WIDTH-bit result `c`, so carries, full products and quotient/remainder pairs are kept without loss.
- Leaf datapath block, driven by a stimulus interface and observed at the top level.

---
 rtl/alu.sv | 61 ++++++
 tb/tb_alu.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: registered single-cycle arithmetic/logic unit with a 2*WIDTH-bit result.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears c
//   a, b   : WIDTH-bit operands (unsigned unless the opcode says otherwise)
//   opcode : 4-bit operation select, all 16 codes defined
//   c      : 2*WIDTH-bit registered result, valid one edge after the inputs
module alu #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [3:0]           opcode,
   output logic [2*WIDTH-1:0]   c
);
   localparam int S  = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;
   logic [S-1:0]     w_sh;
   logic [W2-1:0]    w_a;
   logic [W2-1:0]    w_b;
   logic [WIDTH-1:0] w_asr;
   logic [W2-1:0]    w_rot;
   logic [W2-1:0]    w_div;
   logic [W2-1:0]    w_res;
   logic [W2-1:0]    r_c;
   assign w_sh  = b[S-1:0];
   assign w_a   = {{WIDTH{1'b0}}, a};
   assign w_b   = {{WIDTH{1'b0}}, b};
   assign w_asr = WIDTH'($signed(a) >>> w_sh);
   // the upper half of {a,a} shifted left is a rotated left within WIDTH bits
   assign w_rot = {a, a} << w_sh;
   // remainder in the upper half, quotient in the lower; divide by zero saturates
   assign w_div = (b == '0) ? '1 : {a % b, a / b};
   always_comb begin
      w_res = '0;
      case (opcode)
         4'd0:  w_res = w_a + w_b;
         4'd1:  w_res = w_a - w_b;
         4'd2:  w_res = w_a * w_b;
         4'd3:  w_res = w_div;
         4'd4:  w_res = w_a & w_b;
         4'd5:  w_res = w_a | w_b;
         4'd6:  w_res = w_a ^ w_b;
         4'd7:  w_res = {{WIDTH{1'b0}}, ~a};
         4'd8:  w_res = w_a << w_sh;
         4'd9:  w_res = w_a >> w_sh;
         4'd10: w_res = {{WIDTH{1'b0}}, w_asr};
         4'd11: w_res = {{WIDTH{1'b0}}, w_rot[W2-1:WIDTH]};
         4'd12: w_res = w_a + 1'b1;
         4'd13: w_res = w_a - 1'b1;
         4'd14: w_res = {{(W2-3){1'b0}}, a > b, a < b, a == b};
         4'd15: w_res = w_b;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_c <= '0;
      else       r_c <= w_res;
   end
   assign c = r_c;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu at WIDTH=8, directed edge cases plus random back-to-back traffic.
module tb_alu;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic [3:0]  opcode = '0;
   logic [15:0] c;
   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   alu #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .opcode(opcode), .c(c)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] xe;
      logic [15:0] ye;
      logic [7:0]  t;
      int          s;
      xe = {8'h00, x};
      ye = {8'h00, y};
      t  = x;
      s  = int'(y[2:0]);
      case (op)
         4'd0:  return xe + ye;
         4'd1:  return xe - ye;
         4'd2:  return xe * ye;
         4'd3:  return (y == 0) ? 16'hFFFF : {x % y, x / y};
         4'd4:  return xe & ye;
         4'd5:  return xe | ye;
         4'd6:  return xe ^ ye;
         4'd7:  return {8'h00, ~x};
         4'd8:  begin for (int i = 0; i < s; i++) xe = {xe[14:0], 1'b0}; return xe; end
         4'd9:  begin for (int i = 0; i < s; i++) t = {1'b0, t[7:1]}; return {8'h00, t}; end
         4'd10: begin for (int i = 0; i < s; i++) t = {t[7], t[7:1]}; return {8'h00, t}; end
         4'd11: begin for (int i = 0; i < s; i++) t = {t[6:0], t[7]}; return {8'h00, t}; end
         4'd12: return xe + 16'd1;
         4'd13: return xe - 16'd1;
         4'd14: return {13'd0, x > y, x < y, x == y};
         default: return ye;
      endcase
   endfunction
   task automatic drive(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
      @(negedge clk);
      opcode = op;
      a = x;
      b = y;
      exp_q.push_back(exp);
   endtask
   task automatic collect(input string tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) check({tag, "_empty"}, c, 16'hDEAD);
      else check(tag, c, exp_q.pop_front());
   endtask
   task automatic step(input string tag, input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
      drive(op, x, y, exp);
      collect(tag);
   endtask
   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_init", c, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      step("or_ff", 4'd5, 8'hFF, 8'h00, 16'h00FF);
      #2;
      reset = 1'b1;
      #1;
      check("reset_async", c, 16'h0000);
      @(posedge clk);
      #1;
      check("reset_hold1", c, 16'h0000);
      @(posedge clk);
      #1;
      check("reset_hold2", c, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      step("post_reset_add", 4'd0, 8'h0A, 8'h05, 16'h000F);
      step("add_carry", 4'd0,  8'hFF, 8'h01, 16'h0100);
      step("sub_wrap",  4'd1,  8'h03, 8'h05, 16'hFFFE);
      step("mul_full",  4'd2,  8'hFF, 8'hFF, 16'hFE01);
      step("dec_zero",  4'd13, 8'h00, 8'h00, 16'hFFFF);
      step("inc_ff",    4'd12, 8'hFF, 8'h00, 16'h0100);
      step("div_17_5",  4'd3,  8'd17, 8'd5,  16'h0203);
      step("div_zero",  4'd3,  8'd17, 8'd0,  16'hFFFF);
      step("and",       4'd4,  8'hA5, 8'h0F, 16'h0005);
      step("or",        4'd5,  8'hA5, 8'h0F, 16'h00AF);
      step("xor",       4'd6,  8'hA5, 8'h0F, 16'h00AA);
      step("not",       4'd7,  8'hA5, 8'h0F, 16'h005A);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] sb;
         sb = (k == 0) ? 8'h01 : 8'h09;
         step("shl", 4'd8,  8'h81, sb, 16'h0102);
         step("shr", 4'd9,  8'h81, sb, 16'h0040);
         step("asr", 4'd10, 8'h81, sb, 16'h00C0);
         step("rol", 4'd11, 8'h81, sb, 16'h0003);
      end
      step("cmp_eq", 4'd14, 8'h33, 8'h33, 16'h0001);
      step("cmp_lt", 4'd14, 8'h01, 8'h02, 16'h0002);
      step("cmp_gt", 4'd14, 8'h09, 8'h02, 16'h0004);
      step("passb",  4'd15, 8'h00, 8'h7E, 16'h007E);
      // back-to-back: inputs change every negedge, each result checked one edge later
      drive(4'd0, 8'h11, 8'h22, model(4'd0, 8'h11, 8'h22));
      for (int i = 0; i < 64; i++) begin
         logic [3:0] op;
         logic [7:0] x;
         logic [7:0] y;
         op = 4'(i);
         x  = 8'($urandom);
         y  = (i % 7 == 3) ? 8'h00 : 8'($urandom);
         if (i == 32) begin
            @(negedge clk);
            opcode = op;
            a = x;
            b = y;
            #2;
            reset = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            check("b2b_reset", c, 16'h0000);
            @(negedge clk);
            reset = 1'b0;
            drive(op, x, y, model(op, x, y));
         end else begin
            fork
               drive(op, x, y, model(op, x, y));
               collect("b2b");
            join
         end
      end
      collect("b2b_last");
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
